// File: rtl/code_line_loader_if.sv
// Fabric-side bus of the command line loader: REQUEST/EN arbitration plus
// address/write/read strobes and data.
interface code_line_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [3:0]        NUMBER_UNIT;
  logic              REQUEST;
  logic              EN;
  logic [ADDR_W-1:0] FAB_ADDR;
  logic              ADDRFD;
  logic              WRITEFD;
  logic              READFD;
  logic [DATA_W-1:0] FAB_WDAT;
  logic [DATA_W-1:0] FAB_RDAT;
  logic              BUSY_SLAVE;

  modport master (
    output NUMBER_UNIT, REQUEST, FAB_ADDR, ADDRFD, WRITEFD, READFD, FAB_WDAT,
    input  EN, FAB_RDAT, BUSY_SLAVE
  );

  modport slave (
    input  NUMBER_UNIT, REQUEST, FAB_ADDR, ADDRFD, WRITEFD, READFD, FAB_WDAT,
    output EN, FAB_RDAT, BUSY_SLAVE
  );
endinterface

// File: rtl/code_line_loader.sv
// Command line loader: optionally flushes the L1 line, then refills a LINE_WORDS-deep
// command buffer over the fabric. Optional grant timeout: define LOADER_TIMEOUT_EN.
module code_line_loader #(
  parameter int UNIT_ID    = 1,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 255,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              CLK_B,
  input  logic              RESET,
  input  logic              LOAD_REQ,
  input  logic              FLUSH_REQ,
  input  logic [ADDR_W-1:0] LINE_ADDR,
  input  logic [IDX_W-1:0]  CMD_IDX,
  output logic [DATA_W-1:0] COMMAND,
  output logic              LINE_VALID,
  output logic              store_busy,
  output logic [IDX_W-1:0]  L1ADR,
  output logic              L1RD,
  input  logic [DATA_W-1:0] L1_RDAT,
  output logic              ERR,
  code_line_loader_if.master fab
);

  localparam logic [2:0] ST_SLEEP  = 3'd0;
  localparam logic [2:0] ST_TURN   = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WRITEL = 3'd3;
  localparam logic [2:0] ST_READL  = 3'd4;
  localparam logic [2:0] ST_LOAD   = 3'd5;

  localparam logic [IDX_W-1:0]  CNT_LAST  = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_WORDS - 1);

  logic [2:0]        state_r;
  logic [IDX_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] base_r;
  logic              flush_r;
  logic              line_valid_r;
  logic [DATA_W-1:0] command_r;
  logic              err_r;
  logic [DATA_W-1:0] buf_r [LINE_WORDS];

  logic              xfer_s;
  logic              request_s;
  logic              addrfd_s;
  logic              writefd_s;
  logic              readfd_s;
  logic              l1rd_s;
  logic [IDX_W-1:0]  l1adr_s;
  logic [ADDR_W-1:0] fab_addr_s;

`ifdef LOADER_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt_r;
`endif

  // A fabric beat completes only with grant present and slave not stalling
  assign xfer_s = fab.EN & ~fab.BUSY_SLAVE;

  // Control FSM, word counter, line base and status flags
  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET) begin
      state_r      <= ST_SLEEP;
      cnt_r        <= '0;
      base_r       <= '0;
      flush_r      <= 1'b0;
      line_valid_r <= 1'b0;
      err_r        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      wait_cnt_r   <= '0;
`endif
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_SLEEP: begin
`ifdef LOADER_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
          if (LOAD_REQ || FLUSH_REQ) begin
            base_r       <= LINE_ADDR & BASE_MASK;
            flush_r      <= FLUSH_REQ;
            line_valid_r <= 1'b0;
            state_r      <= ST_TURN;
          end
        end
        ST_TURN: begin
`ifdef LOADER_TIMEOUT_EN
          if (fab.EN) begin
            state_r <= ST_ADDR;
          end else if (wait_cnt_r == WAIT_LAST) begin
            err_r   <= 1'b1;
            state_r <= ST_SLEEP;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
`else
          if (fab.EN) begin
            state_r <= ST_ADDR;
          end
`endif
        end
        ST_ADDR: begin
          if (xfer_s) begin
            cnt_r   <= '0;
            state_r <= flush_r ? ST_WRITEL : ST_READL;
          end
        end
        ST_WRITEL: begin
          if (xfer_s) begin
            if (cnt_r == CNT_LAST) begin
              cnt_r   <= '0;
              state_r <= ST_READL;
            end else begin
              cnt_r <= cnt_r + IDX_W'(1);
            end
          end
        end
        ST_READL: begin
          if (xfer_s) begin
            // Counter wraps to zero on the last word
            cnt_r <= cnt_r + IDX_W'(1);
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          line_valid_r <= 1'b1;
          state_r      <= ST_SLEEP;
        end
        default: begin
          state_r <= ST_SLEEP;
        end
      endcase
    end
  end

  // Line buffer capture; contents are deliberately left unreset
  always_ff @(posedge CLK_B) begin
    if ((state_r == ST_READL) && xfer_s) begin
      buf_r[cnt_r] <= fab.FAB_RDAT;
    end
  end

  // Registered command read port, tracks CMD_IDX with one cycle latency
  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET) begin
      command_r <= '0;
    end else begin
      command_r <= buf_r[CMD_IDX];
    end
  end

  // Bus strobes decoded from the registered state
  always_comb begin
    request_s  = 1'b0;
    addrfd_s   = 1'b0;
    writefd_s  = 1'b0;
    readfd_s   = 1'b0;
    l1rd_s     = 1'b0;
    l1adr_s    = '0;
    fab_addr_s = base_r;
    case (state_r)
      ST_TURN: begin
        request_s = 1'b1;
      end
      ST_ADDR: begin
        request_s = 1'b1;
        addrfd_s  = 1'b1;
      end
      ST_WRITEL: begin
        request_s  = 1'b1;
        writefd_s  = 1'b1;
        l1rd_s     = 1'b1;
        l1adr_s    = cnt_r;
        fab_addr_s = base_r + ADDR_W'(cnt_r);
      end
      ST_READL: begin
        request_s  = 1'b1;
        readfd_s   = 1'b1;
        fab_addr_s = base_r + ADDR_W'(cnt_r);
      end
      default: begin
        request_s = 1'b0;
      end
    endcase
  end

  assign fab.NUMBER_UNIT = 4'(UNIT_ID);
  assign fab.REQUEST     = request_s;
  assign fab.ADDRFD      = addrfd_s;
  assign fab.WRITEFD     = writefd_s;
  assign fab.READFD      = readfd_s;
  assign fab.FAB_ADDR    = fab_addr_s;
  assign fab.FAB_WDAT    = L1_RDAT;

  assign COMMAND    = command_r;
  assign LINE_VALID = line_valid_r;
  assign store_busy = (state_r != ST_SLEEP);
  assign L1ADR      = l1adr_s;
  assign L1RD       = l1rd_s;
  assign ERR        = err_r;

endmodule

// File: tb/tb_code_line_loader.sv
// Directed bench for code_line_loader with a fabric/L1 model and address/data scoreboard.
module tb_code_line_loader;

`ifdef LOADER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 10;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        CLK_B = 1'b0;
  logic        RESET = 1'b0;
  logic        LOAD_REQ = 1'b0;
  logic        FLUSH_REQ = 1'b0;
  logic [7:0]  LINE_ADDR = 8'h00;
  logic [1:0]  CMD_IDX = 2'd0;
  logic [15:0] COMMAND;
  logic        LINE_VALID;
  logic        store_busy;
  logic [1:0]  L1ADR;
  logic        L1RD;
  logic [15:0] L1_RDAT;
  logic        ERR;

  logic [15:0] l1_mem [4];

  code_line_loader_if #(.DATA_W(16), .ADDR_W(8)) fab_if ();

  code_line_loader #(
    .UNIT_ID(1), .DATA_W(16), .ADDR_W(8), .LINE_WORDS(4), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK_B(CLK_B), .RESET(RESET), .LOAD_REQ(LOAD_REQ), .FLUSH_REQ(FLUSH_REQ),
    .LINE_ADDR(LINE_ADDR), .CMD_IDX(CMD_IDX), .COMMAND(COMMAND),
    .LINE_VALID(LINE_VALID), .store_busy(store_busy), .L1ADR(L1ADR), .L1RD(L1RD),
    .L1_RDAT(L1_RDAT), .ERR(ERR), .fab(fab_if)
  );

  always #5 CLK_B = ~CLK_B;

  // Memory model: each fabric address returns 0xA000 + address
  assign fab_if.FAB_RDAT = 16'hA000 + {8'h00, fab_if.FAB_ADDR};
  assign L1_RDAT = L1RD ? l1_mem[L1ADR] : 16'h0000;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_seen = 0;
  int start;
  int n;
  logic [7:0]  q_aph [$];
  logic [7:0]  q_rd  [$];
  logic [23:0] q_wr  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every completing beat against the scoreboard queues
  task automatic monitor();
    logic [23:0] w;
    if (ERR) err_seen++;
    if (fab_if.EN && !fab_if.BUSY_SLAVE) begin
      if (fab_if.ADDRFD) begin
        if (q_aph.size() == 0) check("addr_unexpected", 32'(q_aph.size()), 32'd1);
        else check("addr_phase", 32'(fab_if.FAB_ADDR), 32'(q_aph.pop_front()));
      end
      if (fab_if.READFD) begin
        if (q_rd.size() == 0) check("rd_unexpected", 32'(q_rd.size()), 32'd1);
        else check("rd_addr", 32'(fab_if.FAB_ADDR), 32'(q_rd.pop_front()));
      end
      if (fab_if.WRITEFD) begin
        if (q_wr.size() == 0) check("wr_unexpected", 32'(q_wr.size()), 32'd1);
        else begin
          w = q_wr.pop_front();
          check("wr_addr", 32'(fab_if.FAB_ADDR), 32'(w[23:16]));
          check("wr_data", 32'(fab_if.FAB_WDAT), 32'(w[15:0]));
          check("wr_l1rd", 32'(L1RD), 32'd1);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK_B);
    monitor();
    @(posedge CLK_B);
    #1;
    cyc++;
  endtask

  task automatic push_line(input logic [7:0] base);
    q_aph.push_back(base);
    for (int i = 0; i < 4; i++) q_rd.push_back(base + 8'(i));
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    while (!LINE_VALID && cnt < budget) begin
      tick();
      cnt++;
    end
    if (!LINE_VALID) check("valid_timeout", 32'(LINE_VALID), 32'd1);
  endtask

  task automatic check_line(input logic [7:0] base);
    check("queues_empty", 32'(q_aph.size() + q_rd.size() + q_wr.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      CMD_IDX = 2'(i);
      tick();
      check("command", 32'(COMMAND), 32'(16'hA000 + {8'h00, base + 8'(i)}));
    end
  endtask

  initial begin
    fab_if.EN = 1'b0;
    fab_if.BUSY_SLAVE = 1'b0;
    for (int i = 0; i < 4; i++) l1_mem[i] = 16'(i + 1);

    // Reset state
    #12;
    check("rst_busy", 32'(store_busy), 32'd0);
    check("rst_request", 32'(fab_if.REQUEST), 32'd0);
    check("rst_valid", 32'(LINE_VALID), 32'd0);
    check("rst_command", 32'(COMMAND), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_strobes", 32'({fab_if.ADDRFD, fab_if.READFD, fab_if.WRITEFD, L1RD}), 32'd0);
    check("unit", 32'(fab_if.NUMBER_UNIT), 32'd1);
    tick();
    RESET = 1'b1;
    tick();

    // Plain load at 0x13, grant delayed by 3 cycles
    push_line(8'h10);
    LINE_ADDR = 8'h13;
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
    check("a_request", 32'(fab_if.REQUEST), 32'd1);
    check("a_busy", 32'(store_busy), 32'd1);
    check("a_valid_clr", 32'(LINE_VALID), 32'd0);
    repeat (3) tick();
    check("a_turn_hold", 32'({fab_if.REQUEST, fab_if.ADDRFD}), 32'd2);
    fab_if.EN = 1'b1;
    wait_valid(20, n);
    check("a_cycles", 32'(n), 32'd7);
    check("a_request_off", 32'(fab_if.REQUEST), 32'd0);
    check_line(8'h10);

    // Flush + load together behaves as flush at 0x20
    for (int i = 0; i < 4; i++) q_wr.push_back({8'h20 + 8'(i), 16'(i + 1)});
    push_line(8'h20);
    LINE_ADDR = 8'h20;
    LOAD_REQ = 1'b1;
    FLUSH_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
    FLUSH_REQ = 1'b0;
    wait_valid(30, n);
    check("b_cycles", 32'(n), 32'd11);
    check_line(8'h20);

    // Slave stall and grant drop during reads at 0x40
    push_line(8'h40);
    start = cyc;
    LINE_ADDR = 8'h40;
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
    repeat (3) tick();
    fab_if.BUSY_SLAVE = 1'b1;
    tick();
    tick();
    check("c_busy_hold", 32'(fab_if.FAB_ADDR), 32'h41);
    fab_if.BUSY_SLAVE = 1'b0;
    tick();
    fab_if.EN = 1'b0;
    tick();
    check("c_en_hold", 32'(fab_if.FAB_ADDR), 32'h42);
    check("c_en_readfd", 32'(fab_if.READFD), 32'd1);
    fab_if.EN = 1'b1;
    wait_valid(20, n);
    check("c_cycles", 32'(cyc - start), 32'd11);
    check_line(8'h40);

    // Top-of-space line at 0xFE; a second request mid-read is dropped
    push_line(8'hFC);
    start = cyc;
    LINE_ADDR = 8'hFE;
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
    tick();
    tick();
    LINE_ADDR = 8'h80;
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
    wait_valid(20, n);
    check("d_cycles", 32'(cyc - start), 32'd8);
    tick();
    tick();
    check("d_idle", 32'(store_busy), 32'd0);
    check_line(8'hFC);

    // Grant never arrives
    fab_if.EN = 1'b0;
    err_seen = 0;
    LINE_ADDR = 8'h30;
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    repeat (TB_TIMEOUT - 1) tick();
    check("e_pre_request", 32'(fab_if.REQUEST), 32'd1);
    check("e_pre_err", 32'(ERR), 32'd0);
    tick();
    check("e_err", 32'(ERR), 32'd1);
    check("e_request", 32'(fab_if.REQUEST), 32'd0);
    check("e_busy", 32'(store_busy), 32'd0);
    check("e_valid", 32'(LINE_VALID), 32'd0);
    tick();
    check("e_err_pulse", 32'(ERR), 32'd0);
`else
    repeat (20) tick();
    check("e_wait_request", 32'(fab_if.REQUEST), 32'd1);
    check("e_wait_busy", 32'(store_busy), 32'd1);
    check("e_no_err", 32'(err_seen), 32'd0);
    push_line(8'h30);
    fab_if.EN = 1'b1;
    wait_valid(20, n);
    check_line(8'h30);
`endif

    // Reset in the middle of a read burst
    fab_if.EN = 1'b1;
    push_line(8'h50);
    LINE_ADDR = 8'h50;
    LOAD_REQ = 1'b1;
    tick();
    LOAD_REQ = 1'b0;
    repeat (3) tick();
    check("f_readfd", 32'(fab_if.READFD), 32'd1);
    RESET = 1'b0;
    #1;
    check("f_strobes", 32'({fab_if.ADDRFD, fab_if.READFD, fab_if.WRITEFD, L1RD}), 32'd0);
    check("f_request", 32'(fab_if.REQUEST), 32'd0);
    check("f_valid", 32'(LINE_VALID), 32'd0);
    check("f_busy", 32'(store_busy), 32'd0);
    check("f_command", 32'(COMMAND), 32'd0);
    q_aph.delete();
    q_rd.delete();
    tick();
    RESET = 1'b1;
    tick();
    tick();
    check("f_sleep", 32'(store_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_line_loader.md
Name: code_line_loader

Overview:
Parametrised successor to the single-unit command loader. Refills a LINE_WORDS-deep command line buffer from the memory fabric and optionally writes back (flushes) the core's L1 data words first. Arbitration uses the REQUEST/EN handshake of the fabric controller. Single clock domain; the core reads commands by index from the line buffer.

Parameters:
UNIT_ID, 1, fabric unit number driven on NUMBER_UNIT
DATA_W, 16, width of a fabric data word, an L1 word and a command
ADDR_W, 8, fabric address width (segment length)
LINE_WORDS, 4, words per line; power of two, >=2; IDX_W = log2(LINE_WORDS)
TIMEOUT, 255, grant-wait limit in cycles (used only with LOADER_TIMEOUT_EN)

Ports:
CLK_B  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
LOAD_REQ  in  1  core request: fetch line at LINE_ADDR
FLUSH_REQ  in  1  core request: write back L1 line, then fetch
LINE_ADDR  in  ADDR_W  line base address; low IDX_W bits ignored (forced 0)
CMD_IDX  in  IDX_W  core command read index
COMMAND  out  DATA_W  registered buffer[CMD_IDX]
LINE_VALID  out  1  buffer holds a complete line
store_busy  out  1  loader is not in SLEEP
L1ADR  out  IDX_W  L1 word index during write-back
L1RD  out  1  L1 read strobe
L1_RDAT  in  DATA_W  L1 word, valid in the same cycle as L1ADR/L1RD
NUMBER_UNIT  out  4  UNIT_ID[3:0]
REQUEST  out  1  fabric access request
EN  in  1  fabric grant
FAB_ADDR  out  ADDR_W  fabric address
ADDRFD  out  1  address phase strobe
WRITEFD  out  1  write data strobe
READFD  out  1  read data strobe
FAB_WDAT  out  DATA_W  write data (= L1_RDAT)
FAB_RDAT  in  DATA_W  read data
BUSY_SLAVE  in  1  slave stall; no transfer completes while high
ERR  out  1  one-cycle grant-timeout pulse

Behaviour:
- Reset: STATE=SLEEP, cnt=0, base=0, flush flag=0, LINE_VALID=0, COMMAND=0, ERR=0, buffer contents undefined; all strobes and REQUEST low.
- States: SLEEP=0, TURN=1, ADDR=2, WRITEL=3, READL=4, LOAD=5; any other code returns to SLEEP. Strobes are decoded from the registered state.
- SLEEP: if LOAD_REQ|FLUSH_REQ: latch base={LINE_ADDR[ADDR_W-1:IDX_W],0}, flush=FLUSH_REQ (FLUSH wins if both are high), clear LINE_VALID, go to TURN. Requests arriving in any other state are dropped.
- TURN: REQUEST=1; EN=1 -> ADDR.
- ADDR: REQUEST=1, ADDRFD=1, FAB_ADDR=base. On !BUSY_SLAVE&EN go to WRITEL if flush, otherwise READL; cnt=0.
- WRITEL: REQUEST=1, L1RD=1, WRITEFD=1, L1ADR=cnt, FAB_ADDR=base+cnt (mod 2^ADDR_W), FAB_WDAT=L1_RDAT. A word completes on EN&!BUSY_SLAVE, then cnt++. After word LINE_WORDS-1: cnt=0, go to READL.
- READL: REQUEST=1, READFD=1, FAB_ADDR=base+cnt. On EN&!BUSY_SLAVE: buffer[cnt]<=FAB_RDAT, cnt++. After the last word go to LOAD.
- EN low during ADDR/WRITEL/READL stalls the transfer (state and cnt hold); it never aborts.
- LOAD: REQUEST=0, set LINE_VALID, go to SLEEP (one cycle).
- store_busy = (STATE!=SLEEP).
- COMMAND updates every cycle from buffer[CMD_IDX] (1-cycle latency), including during a refill.
- Reset mid-operation: immediate return to the reset values; the partial line is discarded.

Optional Feature:
LOADER_TIMEOUT_EN: defined -> an 8+-bit wait counter runs in TURN. If EN is still low after TIMEOUT cycles: ERR pulses for 1 cycle, REQUEST drops, return to SLEEP, LINE_VALID stays 0. Not defined -> TURN waits forever and ERR is tied 0.

Test Plan:
Reset with RESET=0 mid-READL -> all strobes/REQUEST/LINE_VALID=0 in the same cycle; SLEEP after release.
LOAD_REQ, LINE_ADDR=0x13, EN after 3 cycles, FAB_RDAT=0xA000+addr -> ADDRFD at 0x10; reads 0x10..0x13; buffer={A010,A011,A012,A013}; LINE_VALID=1; CMD_IDX=2 -> COMMAND=0xA012 next cycle.
FLUSH_REQ, LINE_ADDR=0x20, L1 words {1,2,3,4} -> WRITEFD writes 1..4 to 0x20..0x23, then 4 READFD reads; FLUSH+LOAD in the same cycle behaves as FLUSH.
BUSY_SLAVE high for 2 cycles on read word 1, and EN low for 1 cycle on word 2 -> cnt holds; the correct 4 words are captured; total cycles increase by 3.
LINE_ADDR=0xFE, LINE_WORDS=4 -> addresses 0xFC..0xFF with no overflow; second LOAD_REQ during READL is ignored.
LOADER_TIMEOUT_EN, TIMEOUT=10, EN never asserted -> ERR pulse after 10 TURN cycles; REQUEST=0; SLEEP; LINE_VALID=0.
